// File: rtl/down_counter_if.sv
// down_counter_if: control and status bundle for the down counter.
// The master drives the control strobes; the counter drives the status outputs.
interface down_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output en, load, load_val, start,
        input  q, tc, busy, done
    );

    modport slave (
        input  en, load, load_val, start,
        output q, tc, busy, done
    );
endinterface

// File: rtl/down_counter.sv
// down_counter: loadable down counter with an IDLE/RUN/DONE controller and registered tc.
// Define DOWN_COUNTER_RELOAD_EN for auto-reload mode; one-shot mode otherwise.
module down_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic           clk,
    input  logic           rst,
    down_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] rld_nx;
    logic             pulse;
    logic             pulse_nx;
    logic [WIDTH-1:0] clamped;

    assign clamped = (bus.load_val > MAXV) ? MAXV : bus.load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= MAXV;
            rld   <= MAXV;
            pulse <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rld   <= rld_nx;
            pulse <= pulse_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rld_nx   = rld;
        pulse_nx = 1'b0;
        if (bus.load) begin
            // load doubles as abort: it wins over start and en
            cnt_nx   = clamped;
            rld_nx   = clamped;
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (cnt != ZERO) begin
                            state_nx = RUN;
                        end else begin
                            state_nx = DONE;
                            pulse_nx = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        cnt_nx = rld;
                        if (rld != ZERO) begin
                            state_nx = RUN;
                        end else begin
                            pulse_nx = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        if (cnt > ONE) begin
                            cnt_nx = cnt - ONE;
                        end else if (cnt == ONE) begin
                            cnt_nx   = ZERO;
                            pulse_nx = 1'b1;
`ifndef DOWN_COUNTER_RELOAD_EN
                            state_nx = DONE;
`endif
                        end
`ifdef DOWN_COUNTER_RELOAD_EN
                        else begin
                            // reload step at zero keeps the period at rld+1
                            cnt_nx   = rld;
                            pulse_nx = (rld == ZERO);
                        end
`endif
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign bus.q    = cnt;
    assign bus.tc   = pulse;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed and random stimulus on two counters (MAX=7 and MAX=5)
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_down_counter;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic [2:0] lv = 3'd0;

    int vec = 0;
    int err = 0;

    int mx[2] = '{7, 5};
    int mq[2] = '{7, 5};
    int mr[2] = '{7, 5};
    int ms[2] = '{S_IDLE, S_IDLE};
    int mt[2] = '{0, 0};

    down_counter_if #(.WIDTH(3)) ia ();
    down_counter_if #(.WIDTH(3)) ib ();

    assign ia.en       = en;
    assign ia.load     = load;
    assign ia.load_val = lv;
    assign ia.start    = start;
    assign ib.en       = en;
    assign ib.load     = load;
    assign ib.load_val = lv;
    assign ib.start    = start;

    down_counter #(.WIDTH(3), .MAX(7)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    down_counter #(.WIDTH(3), .MAX(5)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mreset(input int k);
        mq[k] = mx[k];
        mr[k] = mx[k];
        ms[k] = S_IDLE;
        mt[k] = 0;
    endtask

    task automatic mstep(input int k);
        int nq;
        int nr;
        int ns;
        int t;
        nq = mq[k];
        nr = mr[k];
        ns = ms[k];
        t  = 0;
        if (load) begin
            nq = (int'(lv) > mx[k]) ? mx[k] : int'(lv);
            nr = nq;
            ns = S_IDLE;
        end else if (start && ms[k] != S_RUN) begin
            nq = (ms[k] == S_DONE) ? mr[k] : mq[k];
            if (nq == 0) begin
                ns = S_DONE;
                t  = 1;
            end else begin
                ns = S_RUN;
            end
        end else if (ms[k] == S_RUN && en) begin
            if (mq[k] == 0) begin
                nq = mr[k];
                t  = (mr[k] == 0) ? 1 : 0;
            end else begin
                nq = mq[k] - 1;
                if (nq == 0) begin
                    t = 1;
`ifndef DOWN_COUNTER_RELOAD_EN
                    ns = S_DONE;
`endif
                end
            end
        end
        mq[k] = nq;
        mr[k] = nr;
        ms[k] = ns;
        mt[k] = t;
    endtask

    // model update and per-cycle compare of both counters
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0);
            mstep(1);
        end
        #1;
        chk("a_q", 32'(ia.q), 32'(mq[0]));
        chk("a_tc", 32'(ia.tc), 32'(mt[0]));
        chk("a_busy", 32'(ia.busy), 32'(ms[0] == S_RUN));
        chk("a_done", 32'(ia.done), 32'(ms[0] == S_DONE));
        chk("b_q", 32'(ib.q), 32'(mq[1]));
        chk("b_tc", 32'(ib.tc), 32'(mt[1]));
        chk("b_busy", 32'(ib.busy), 32'(ms[1] == S_RUN));
        chk("b_done", 32'(ib.done), 32'(ms[1] == S_DONE));
    end

    task automatic do_load(input logic [2:0] v);
        @(negedge clk);
        load  = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        lv    = v;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int ge[6];
        logic gp[6];
`ifdef DOWN_COUNTER_RELOAD_EN
        int rs[6];
`endif
        ge = '{3, 3, 3, 2, 1, 0};
        gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("lit_rst_q", 32'(ia.q), 32'd7);
        chk("lit_rst_bq", 32'(ib.q), 32'd5);
        chk("lit_rst_busy", 32'(ia.busy), 32'd0);

        // mid-count asynchronous reset
        do_load(3'd5);
        en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        chk("lit_mid_q", 32'(ia.q), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("lit_arst_q", 32'(ia.q), 32'd7);
        chk("lit_arst_busy", 32'(ia.busy), 32'd0);
        chk("lit_arst_done", 32'(ia.done), 32'd0);
        chk("lit_arst_tc", 32'(ia.tc), 32'd0);
        #1 rst = 1'b1;

        // full countdown from reset value
        @(negedge clk);
        start = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lit_start_q", 32'(ia.q), 32'd7);
        chk("lit_start_busy", 32'(ia.busy), 32'd1);
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            chk("lit_cd_q", 32'(ia.q), 32'(i));
            chk("lit_cd_tc", 32'(ia.tc), 32'(i == 0));
        end
`ifndef DOWN_COUNTER_RELOAD_EN
        chk("lit_os_done", 32'(ia.done), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("lit_hold_q", 32'(ia.q), 32'd0);
            chk("lit_hold_tc", 32'(ia.tc), 32'd0);
            chk("lit_hold_busy", 32'(ia.busy), 32'd0);
        end
`endif

        // enable gating
        do_load(3'd4);
        chk("lit_gate_q0", 32'(ia.q), 32'd4);
        en = gp[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("lit_gate_q", 32'(ia.q), 32'(ge[i]));
            chk("lit_gate_tc", 32'(ia.tc), 32'(i == 5));
            en = (i < 5) ? gp[i+1] : 1'b0;
        end

        // clamp and priority: load with start on the same edge
        @(negedge clk);
        load  = 1'b1;
        start = 1'b1;
        lv    = 3'd7;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        chk("lit_clamp_bq", 32'(ib.q), 32'd5);
        chk("lit_clamp_bbusy", 32'(ib.busy), 32'd0);
        chk("lit_clamp_aq", 32'(ia.q), 32'd7);

        // zero load then start
        do_load(3'd0);
        chk("lit_zero_done", 32'(ia.done), 32'd1);
        chk("lit_zero_tc", 32'(ia.tc), 32'd1);
        @(negedge clk);
        chk("lit_zero_tc2", 32'(ia.tc), 32'd0);

`ifndef DOWN_COUNTER_RELOAD_EN
        do_load(3'd3);
        en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        chk("lit_rld3_done", 32'(ia.done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lit_rld3_busy", 32'(ia.busy), 32'd1);
        chk("lit_rld3_q", 32'(ia.q), 32'd3);
`else
        rs = '{1, 0, 2, 1, 0, 2};
        do_load(3'd2);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("lit_ar_q", 32'(ia.q), 32'(rs[i]));
            chk("lit_ar_tc", 32'(ia.tc), 32'(rs[i] == 0));
            chk("lit_ar_busy", 32'(ia.busy), 32'd1);
        end
        en = 1'b0;
`endif

        // random phase, model-checked every cycle
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 5) == 0);
            en    = ($urandom_range(0, 3) != 0);
            lv    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/down_counter.md
# down_counter

Synchronous, loadable, parameterized down counter with a start/run/done controller and a registered terminal-count pulse. It counts in the opposite direction to the team's ripple up counter. It serves as the countdown timer and prescaler element that sits beside the up-count chain in the same designs. The whole block runs on a single clock, so no stage clocks another.

## Interface
- WIDTH, 3, counter width in bits.
- MAX, 7, highest legal count and reset value; legal range is 1..2^WIDTH-1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  count enable; a step occurs only on a clk edge with en=1 in RUN.
- load  in  1  synchronous load and abort strobe.
- load_val  in  WIDTH  value for q and the reload register; clamped to MAX.
- start  in  1  begin (or restart) counting.
- q  out  WIDTH  current count.
- tc  out  1  terminal-count pulse, one cycle wide, registered.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.

## Operation
- Registers: q, rld (reload value), state ∈ {IDLE, RUN, DONE}, tc.
- Reset (rst=0, asynchronous, effective at any time including mid-count): q=MAX, rld=MAX, state=IDLE, tc=0, busy=0, done=0.
- Input priority on each edge: load > start > en.
- load in any state:
  - q and rld take min(load_val, MAX).
  - state goes to IDLE; tc=0.
  - start and en are ignored that cycle.
- start in IDLE:
  - If q≠0: go to RUN, q unchanged.
  - If q=0: go to DONE and pulse tc.
- start in DONE: q←rld, go to RUN. If rld=0, go to DONE again and pulse tc instead.
- start in RUN: no effect.
- RUN with en=1:
  - q>1: q←q−1.
  - q=1: q←0 and pulse tc. Without the reload feature, state←DONE.
  - q=0 (reachable only with the reload feature): q←rld. If rld=0, pulse tc again.
- RUN with en=0: all registers hold.
- Arithmetic: unsigned modulo-2^WIDTH decrement, but the count never goes below 0. Zero is handled explicitly by the rules above.
- busy and done are decoded from registered state; they are glitch-free.

## Timing
- A load, start or count step is visible on q, busy and done one clk edge after the sampling edge.
- tc rises on the same edge at which q becomes 0, or at which the controller enters DONE with q=0. It is high for exactly one cycle.
- From start to tc with initial count N≥1 and en held high: N+1 edges (1 start edge plus N count edges).
- With the reload feature, the period between tc pulses is rld+1 enabled cycles. The extra cycle is the reload step at q=0.
- Deasserting rst is synchronous-safe only if the release meets recovery/removal timing to clk. The block provides no reset synchronizer.

## Configuration
- DOWN_COUNTER_RELOAD_EN defined:
  - Auto-reload mode. On reaching 0, RUN is kept.
  - The next enabled cycle loads rld; counting continues indefinitely until load or reset.
  - DONE is entered only via start with q=0, or start from DONE with rld=0.
- DOWN_COUNTER_RELOAD_EN undefined:
  - One-shot mode. Reaching 0 moves the controller to DONE, where it holds q=0 until start or load.
  - The q=0 RUN branch is not compiled.

## Test plan
- Reset mid-count: load 5, start, two en cycles (q=3), then pulse rst=0 → q=7, busy=0, done=0, tc=0 immediately, with no clk edge required.
- One-shot, WIDTH=3, MAX=7, reload undefined: rst release, start, en held high → q steps 7,6,…,0. tc is high for one cycle on the edge where q=0, then done=1, busy=0, and q holds 0 for 10 further cycles.
- Enable gating: load 4, start, en toggled 1,0,0,1,1,1 → q goes 4,3,3,3,2,1,0. tc asserts only at the final step.
- Load clamp and priority: MAX=5. Assert load_val=7 and start on the same edge → q=5, rld=5, state IDLE, busy=0.
- Auto-reload (DOWN_COUNTER_RELOAD_EN), load 2, start, en held → q sequence 2,1,0,2,1,0,2. tc pulses every 3 cycles and busy stays 1.
- Zero cases: load 0 then start → done=1 and a single tc pulse next edge. From DONE with rld=3, start → busy=1, q=3.
